// File: rtl/bus_arbiter_rr.sv
// Bus arbiter for up to 16 masters, with fixed or round-robin priority.
// A grant runs GRANT -> WAIT_ADDR -> STROBE -> HOLD -> RELEASE.
// All outputs are registered. They are computed from the next state.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | bus free; a pending request is arbitrated on each edge
// S_GRANT     | winner latched; one cycle before address decode is checked
// S_WAIT_ADDR | waiting for address_valid_i; timeout down-counter running
// S_STROBE    | data_strobe_o high for STROBE_CYCLES cycles
// S_HOLD      | bus kept until the granted master drops its request
// S_RELEASE   | one idle cycle with grant and target_ready removed
module bus_arbiter_rr #(
  parameter int NUM_MASTERS     = 4,
  parameter int CLK_MAX_TIMEOUT = 10,
  parameter int PRIORITY_MODE   = 1,
  parameter int STROBE_CYCLES   = 1,
  localparam int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] barq_i,
  input  logic                   address_valid_i,
  output logic [NUM_MASTERS-1:0] bagd_o,
  output logic                   target_ready_o,
  output logic                   data_strobe_o,
  output logic                   error_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic [7:0]             err_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_WAIT_ADDR, S_STROBE, S_HOLD, S_RELEASE
  } state_e;

  localparam logic [7:0] TIMEOUT_LOAD = 8'(CLK_MAX_TIMEOUT - 1);
  localparam logic [7:0] STROBE_LOAD  = 8'(STROBE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] bagd_q, bagd_d;
  logic                   target_ready_q, target_ready_d;
  logic                   data_strobe_q, data_strobe_d;
  logic                   error_q, error_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_MASTERS-1:0] win_oh;
  logic                   own_req;
  logic                   timeout_evt;
  logic                   start_grant;

  // The grant is one-hot. This reads the granted master's request without indexing by grant_idx.
  assign own_req = |(barq_i & bagd_q);

  always_comb begin : winner_search
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (PRIORITY_MODE == 1 && NUM_MASTERS > 1) begin
        cand = int'(grant_idx_q) + 1 + i;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      end else begin
        cand = i;
      end
      if (!win_found && ((barq_i >> cand) & NUM_MASTERS'(1)) != '0) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
        win_oh    = NUM_MASTERS'(1) << cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bagd_q         <= '0;
      target_ready_q <= 1'b0;
      data_strobe_q  <= 1'b0;
      error_q        <= 1'b0;
      grant_idx_q    <= IDX_W'(NUM_MASTERS - 1);
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bagd_q         <= bagd_d;
      target_ready_q <= target_ready_d;
      data_strobe_q  <= data_strobe_d;
      error_q        <= error_d;
      grant_idx_q    <= grant_idx_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  // A dropped request beats address_valid_i. address_valid_i beats the timeout.
  always_comb begin : next_state
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          cnt_d   = TIMEOUT_LOAD;
        end
      end
      S_GRANT: state_d = S_WAIT_ADDR;
      S_WAIT_ADDR: begin
        if (!own_req) begin
          state_d = S_RELEASE;
        end else if (address_valid_i) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LOAD;
        end else if (cnt_q == '0) begin
          state_d     = S_RELEASE;
          timeout_evt = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_STROBE: begin
        if (!own_req) begin
          state_d = S_RELEASE;
        end else if (cnt_q == '0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (!own_req) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin : output_decode
    start_grant    = (state_q == S_IDLE) && (state_d == S_GRANT);
    bagd_d         = bagd_q;
    grant_idx_d    = grant_idx_q;
    if (start_grant) begin
      bagd_d      = win_oh;
      grant_idx_d = win_idx;
    end else if (state_d == S_IDLE || state_d == S_RELEASE) begin
      bagd_d = '0;
    end
    target_ready_d = !(state_d inside {S_IDLE, S_RELEASE});
    data_strobe_d  = (state_d == S_STROBE);
    error_d        = timeout_evt;
    err_cnt_d      = err_cnt_q;
    if (timeout_evt && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  assign bagd_o         = bagd_q;
  assign target_ready_o = target_ready_q;
  assign data_strobe_o  = data_strobe_q;
  assign error_o        = error_q;
  assign grant_idx_o    = grant_idx_q;
  assign err_cnt_o      = err_cnt_q;

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of bus masters; legal range 1..16.
REQ-002 Parameter CLK_MAX_TIMEOUT, default 10, clk cycles allowed from grant to address_valid_i; legal range 1..255.
REQ-003 Parameter PRIORITY_MODE, default 1; 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 Parameter STROBE_CYCLES, default 1, width of the data_strobe_o pulse in cycles; legal range 1..15.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 barq_i  input  NUM_MASTERS  bus request, one bit per master, level held for the whole transaction.
REQ-008 address_valid_i  input  1  OR of registered slave selects; high = some slave decoded the address.
REQ-009 bagd_o  output  NUM_MASTERS  bus grant, one-hot or zero, registered.
REQ-010 target_ready_o  output  1  high while a transaction owns the bus; low clears slave selects.
REQ-011 data_strobe_o  output  1  write/read qualifier for the selected slave.
REQ-012 error_o  output  1  one-cycle pulse on address timeout.
REQ-013 grant_idx_o  output  max(1,$clog2(NUM_MASTERS))  binary index of current/last granted master.
REQ-014 err_cnt_o  output  8  saturating count of timeout errors.

Function
REQ-015 States: IDLE, GRANT, WAIT_ADDR, STROBE, HOLD, RELEASE; state, bagd_o, target_ready_o, data_strobe_o, error_o, grant_idx_o, err_cnt_o all registered.
REQ-016 IDLE: bagd_o=0, target_ready_o=0, data_strobe_o=0; if any barq_i bit high at edge k, winner latched and state=GRANT with bagd_o one-hot and target_ready_o=1 after edge k.
REQ-017 Fixed mode: winner = lowest set index of barq_i.
REQ-018 Round-robin: search starts at grant_idx_o+1 modulo NUM_MASTERS, wraps; with a single requester it wins regardless of pointer.
REQ-019 GRANT lasts exactly one cycle, then WAIT_ADDR; timeout counter cleared on entry to GRANT.
REQ-020 WAIT_ADDR: counter increments each cycle; address_valid_i high -> STROBE next edge; counter reaching CLK_MAX_TIMEOUT with address_valid_i low -> RELEASE with error_o=1 for that one cycle and err_cnt_o+1 (saturate at 255).
REQ-021 address_valid_i and timeout in the same cycle: address_valid_i wins, no error.
REQ-022 STROBE: data_strobe_o=1 for exactly STROBE_CYCLES cycles, then HOLD.
REQ-023 HOLD: bagd_o kept until granted barq_i bit low, then RELEASE.
REQ-024 Granted master dropping barq_i in WAIT_ADDR or STROBE: abort to RELEASE next edge, data_strobe_o low from that edge, no error.
REQ-025 RELEASE: one cycle, bagd_o=0, target_ready_o=0, data_strobe_o=0; then IDLE; back-to-back grant earliest one cycle after RELEASE.
REQ-026 Requests from non-granted masters ignored until IDLE; grant never changes mid-transaction.
REQ-027 bagd_o never has more than one bit set; grant_idx_o updated on same edge as bagd_o set, held afterwards.
REQ-028 NUM_MASTERS=1: round-robin degenerates to fixed; grant_idx_o is 1 bit, constant 0.

Reset
REQ-029 rst_n low forces immediately: state=IDLE, bagd_o=0, target_ready_o=0, data_strobe_o=0, error_o=0, grant_idx_o=NUM_MASTERS-1 (so master 0 wins first in round-robin), err_cnt_o=0.
REQ-030 Reset mid-transaction drops the grant without RELEASE cycle and without error; first post-reset grant no earlier than first rising edge with rst_n high.

Verification
REQ-031 N=4, RR: barq_i=4'b1111 held, address_valid_i one cycle after each grant -> grants 0,1,2,3,0 in order, one-cycle data_strobe_o each.
REQ-032 N=4, fixed: barq_i=4'b1010 -> bagd_o=4'b0010 repeatedly; master 3 never granted while master 1 requests.
REQ-033 Timeout=10: barq_i=4'b0100, address_valid_i never high -> error_o pulse exactly 10 cycles after WAIT_ADDR entry, err_cnt_o=1, bagd_o=0 next cycle.
REQ-034 STROBE_CYCLES=3: valid address -> data_strobe_o high exactly 3 cycles; master drops barq_i in 2nd strobe cycle -> strobe low next edge, RELEASE, err_cnt_o unchanged.
REQ-035 Async reset asserted in STROBE between clock edges -> all outputs 0 before next edge; after release, barq_i=4'b1000 in RR -> bagd_o=4'b1000.
REQ-036 256+ forced timeouts -> err_cnt_o stays 255; address_valid_i coincident with final timeout cycle -> no error, STROBE entered.
